// File: rtl/ws2812_pixel_tx_if.sv
// Pixel-word handshake between a frame source and the WS2812 transmitter.
interface ws2812_pixel_tx_if #(
  parameter int BITS_PER_PIX = 24
);
  logic [BITS_PER_PIX-1:0] pix_in;
  logic                    pix_last_in;
  logic                    pix_valid_in;
  logic                    pix_ready_out;

  modport master (
    output pix_in,
    output pix_last_in,
    output pix_valid_in,
    input  pix_ready_out
  );

  modport slave (
    input  pix_in,
    input  pix_last_in,
    input  pix_valid_in,
    output pix_ready_out
  );
endinterface

// File: rtl/ws2812_pixel_tx.sv
// WS2812 serialiser: pixel words in over valid/ready, programmable bit timing, latch gap and underrun detect.
// Optional pixel counter output enabled by defining WS2812_PIX_CNT_EN.
module ws2812_pixel_tx #(
  parameter int BITS_PER_PIX = 24,
  parameter int T0H          = 20,
  parameter int T0L          = 42,
  parameter int T1H          = 40,
  parameter int T1L          = 22,
  parameter int T_RST        = 4000,
  parameter int CNT_W        = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ws2812_pixel_tx_if.slave   pix_if,
  output logic               ws2812_out,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               underrun_out
`ifdef WS2812_PIX_CNT_EN
  ,
  output logic [15:0]        pix_cnt_out
`endif
);

  localparam int IDX_W = (BITS_PER_PIX > 1) ? $clog2(BITS_PER_PIX) : 1;

  localparam logic [CNT_W-1:0] T0H_M1  = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_M1  = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] T1H_M1  = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_M1  = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] TRST_M1 = CNT_W'(T_RST - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(BITS_PER_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        gap_q;
  logic [BITS_PER_PIX-1:0] shift_q;
  logic [IDX_W-1:0]        bit_idx_q;
  logic                    last_q;
  logic                    mid_q;
  logic                    ws_q;
  logic                    frame_done_q;
  logic                    underrun_q;
`ifdef WS2812_PIX_CNT_EN
  logic [15:0]             pix_cnt_q;
`endif

  logic high_end_s;
  logic low_end_s;
  logic final_bit_s;
  logic ready_s;
  logic accept_s;

  // Phase-end decode for the bit currently on the wire (MSB of the shifter).
  always_comb begin
    high_end_s  = 1'b0;
    low_end_s   = 1'b0;
    final_bit_s = (bit_idx_q == {IDX_W{1'b0}});
    if (shift_q[BITS_PER_PIX-1]) begin
      high_end_s = (cnt_q == T1H_M1);
      low_end_s  = (cnt_q == T1L_M1);
    end else begin
      high_end_s = (cnt_q == T0H_M1);
      low_end_s  = (cnt_q == T0L_M1);
    end
    if (state_q == S_IDLE) begin
      ready_s = 1'b1;
    end else if ((state_q == S_LOW) && low_end_s && final_bit_s && !last_q) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = pix_if.pix_valid_in & ready_s;
  end

  // Transmit FSM with all outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      gap_q        <= {CNT_W{1'b0}};
      shift_q      <= {BITS_PER_PIX{1'b0}};
      bit_idx_q    <= {IDX_W{1'b0}};
      last_q       <= 1'b0;
      mid_q        <= 1'b0;
      ws_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef WS2812_PIX_CNT_EN
      pix_cnt_q    <= 16'd0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      cnt_q        <= cnt_q + CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          if (mid_q) begin
            if (gap_q == TRST_M1) begin
              underrun_q <= 1'b1;
              mid_q      <= 1'b0;
              gap_q      <= {CNT_W{1'b0}};
            end else begin
              gap_q <= gap_q + CNT_W'(1);
            end
          end
        end
        S_HIGH: begin
          if (high_end_s) begin
            state_q <= S_LOW;
            ws_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
          end
        end
        S_LOW: begin
          if (low_end_s) begin
            cnt_q <= {CNT_W{1'b0}};
            if (!final_bit_s) begin
              state_q   <= S_HIGH;
              ws_q      <= 1'b1;
              shift_q   <= shift_q << 1;
              bit_idx_q <= bit_idx_q - IDX_W'(1);
            end else if (last_q) begin
              state_q <= S_LATCH;
            end else begin
              // Accept (if any) overrides this below and continues without a gap.
              state_q <= S_IDLE;
              mid_q   <= 1'b1;
              gap_q   <= {CNT_W{1'b0}};
            end
          end
        end
        S_LATCH: begin
          if (cnt_q == TRST_M1) begin
            state_q      <= S_IDLE;
            frame_done_q <= 1'b1;
            cnt_q        <= {CNT_W{1'b0}};
          end
        end
        default: begin
          state_q <= S_IDLE;
          ws_q    <= 1'b0;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase

      if (accept_s) begin
        state_q    <= S_HIGH;
        ws_q       <= 1'b1;
        cnt_q      <= {CNT_W{1'b0}};
        shift_q    <= pix_if.pix_in;
        last_q     <= pix_if.pix_last_in;
        bit_idx_q  <= IDX_TOP;
        mid_q      <= 1'b0;
        gap_q      <= {CNT_W{1'b0}};
        underrun_q <= 1'b0;
      end

`ifdef WS2812_PIX_CNT_EN
      if (accept_s) begin
        pix_cnt_q <= pix_cnt_q + 16'd1;
      end else if (((state_q == S_LATCH) && (cnt_q == TRST_M1)) ||
                   ((state_q == S_IDLE) && mid_q && (gap_q == TRST_M1))) begin
        pix_cnt_q <= 16'd0;
      end else begin
        pix_cnt_q <= pix_cnt_q;
      end
`endif
    end
  end

  assign pix_if.pix_ready_out = ready_s;
  assign ws2812_out           = ws_q;
  assign busy_out             = (state_q != S_IDLE);
  assign frame_done_out       = frame_done_q;
  assign underrun_out         = underrun_q;
`ifdef WS2812_PIX_CNT_EN
  assign pix_cnt_out          = pix_cnt_q;
`endif

endmodule
